// File: rtl/pair_compare_monitor.sv
// Checks the {b,c} outputs of the blocking and non-blocking instances against each other.
// Skips a settle window after start, then counts compared cycles and mismatches and records the first divergence.
module pair_compare_monitor #(
  parameter int WIDTH  = 4,
  parameter int CNT_W  = 8,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] b1,
  input  logic [WIDTH-1:0] c1,
  input  logic [WIDTH-1:0] b2,
  input  logic [WIDTH-1:0] c2,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             first_err_valid,
  output logic [CNT_W-1:0] first_err_idx
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_COMPARE, S_DONE} state_t;

  localparam int               SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam state_t           RUN_ENTRY   = (SETTLE == 0) ? S_COMPARE : S_SETTLE;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  state_t           state_q;
  logic [SW-1:0]    settle_q;
  logic             busy_q, done_q, eq_q, fev_q;
  logic [CNT_W-1:0] cycle_cnt_q, mismatch_cnt_q, fidx_q;

  logic             mismatch;
  logic [CNT_W-1:0] cycle_cnt_d, mismatch_cnt_d;

  assign mismatch       = ({b1, c1} != {b2, c2});
  assign cycle_cnt_d    = sat_inc(cycle_cnt_q);
  assign mismatch_cnt_d = mismatch ? sat_inc(mismatch_cnt_q) : mismatch_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      settle_q       <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      eq_q           <= 1'b1;
      fev_q          <= 1'b0;
      cycle_cnt_q    <= '0;
      mismatch_cnt_q <= '0;
      fidx_q         <= '0;
    end else if (start) begin
      // start restarts from any state and takes priority over stop
      state_q        <= RUN_ENTRY;
      settle_q       <= '0;
      busy_q         <= 1'b1;
      done_q         <= 1'b0;
      eq_q           <= 1'b1;
      fev_q          <= 1'b0;
      cycle_cnt_q    <= '0;
      mismatch_cnt_q <= '0;
      fidx_q         <= '0;
    end else begin
      case (state_q)
        S_SETTLE: begin
          if (stop) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (settle_q == SETTLE_LAST) begin
            state_q <= S_COMPARE;
          end else begin
            settle_q <= settle_q + SW'(1);
          end
        end
        S_COMPARE: begin
          // the cycle carrying stop is still compared
          cycle_cnt_q    <= cycle_cnt_d;
          mismatch_cnt_q <= mismatch_cnt_d;
          eq_q           <= !mismatch;
          if (mismatch && !fev_q) begin
            fev_q  <= 1'b1;
            fidx_q <= cycle_cnt_q;
          end
          if (stop) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign eq              = eq_q;
  assign cycle_cnt       = cycle_cnt_q;
  assign mismatch_cnt    = mismatch_cnt_q;
  assign first_err_valid = fev_q;
  assign first_err_idx   = fidx_q;

endmodule

// File: tb/tb_pair_compare_monitor.sv
// Bench for pair_compare_monitor: two instances (CNT_W=8/SETTLE=2 and CNT_W=4/SETTLE=0) share
// the stimulus and are checked against a run-log reference model plus directed expectations.
module tb_pair_compare_monitor;

  logic       clk = 1'b0;
  logic       rst, start, stop;
  logic [3:0] b1, c1, b2, c2;

  logic       busy0, done0, eq0, fev0;
  logic [7:0] cc0, mc0, fi0;
  logic       busy1, done1, eq1, fev1;
  logic [3:0] cc1, mc1, fi1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pair_compare_monitor #(.WIDTH(4), .CNT_W(8), .SETTLE(2)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .b1(b1), .c1(c1), .b2(b2), .c2(c2),
    .busy(busy0), .done(done0), .eq(eq0), .cycle_cnt(cc0), .mismatch_cnt(mc0),
    .first_err_valid(fev0), .first_err_idx(fi0)
  );

  pair_compare_monitor #(.WIDTH(4), .CNT_W(4), .SETTLE(0)) dut_s (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .b1(b1), .c1(c1), .b2(b2), .c2(c2),
    .busy(busy1), .done(done1), .eq(eq1), .cycle_cnt(cc1), .mismatch_cnt(mc1),
    .first_err_valid(fev1), .first_err_idx(fi1)
  );

  // Reference model: each run is kept as a log of per-compare mismatch bits;
  // every output is derived from that log.
  localparam int MS[2] = '{2, 0};
  localparam int MX[2] = '{255, 15};
  bit mlist[2][0:2047];
  int mlen[2];
  int msince[2];
  bit mact[2];
  bit mdone[2];

  function automatic int clampi(int v, int i);
    return (v > MX[i]) ? MX[i] : v;
  endfunction

  function automatic int f_cnt(int i);
    return clampi(mlen[i], i);
  endfunction

  function automatic int f_mm(int i);
    int n = 0;
    for (int k = 0; k < mlen[i]; k++) n += int'(mlist[i][k]);
    return clampi(n, i);
  endfunction

  function automatic int f_fv(int i);
    for (int k = 0; k < mlen[i]; k++) if (mlist[i][k]) return 1;
    return 0;
  endfunction

  function automatic int f_fi(int i);
    for (int k = 0; k < mlen[i]; k++) if (mlist[i][k]) return clampi(k, i);
    return 0;
  endfunction

  function automatic int f_eq(int i);
    return (mlen[i] == 0) ? 1 : int'(!mlist[i][mlen[i]-1]);
  endfunction

  task automatic model_edge(input bit r, input bit s, input bit p, input bit mis);
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        mact[i] = 0; mdone[i] = 0; mlen[i] = 0; msince[i] = 0;
      end else if (s) begin
        mact[i] = 1; mdone[i] = 0; mlen[i] = 0; msince[i] = 0;
      end else if (mact[i]) begin
        msince[i]++;
        if (msince[i] > MS[i] && mlen[i] < 2048) begin
          mlist[i][mlen[i]] = mis;
          mlen[i]++;
        end
        if (p) begin
          mact[i] = 0; mdone[i] = 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("m0_busy", int'(busy0), int'(mact[0]));
    chk("m0_done", int'(done0), int'(mdone[0]));
    chk("m0_eq",   int'(eq0),   f_eq(0));
    chk("m0_cnt",  int'(cc0),   f_cnt(0));
    chk("m0_mm",   int'(mc0),   f_mm(0));
    chk("m0_fev",  int'(fev0),  f_fv(0));
    chk("m0_fidx", int'(fi0),   f_fi(0));
    chk("m1_busy", int'(busy1), int'(mact[1]));
    chk("m1_done", int'(done1), int'(mdone[1]));
    chk("m1_eq",   int'(eq1),   f_eq(1));
    chk("m1_cnt",  int'(cc1),   f_cnt(1));
    chk("m1_mm",   int'(mc1),   f_mm(1));
    chk("m1_fev",  int'(fev1),  f_fv(1));
    chk("m1_fidx", int'(fi1),   f_fi(1));
  endtask

  task automatic step(input bit r, input bit s, input bit p,
                      input logic [3:0] vb1, input logic [3:0] vc1,
                      input logic [3:0] vb2, input logic [3:0] vc2);
    @(negedge clk);
    rst = r; start = s; stop = p;
    b1 = vb1; c1 = vc1; b2 = vb2; c2 = vc2;
    @(posedge clk);
    model_edge(r, s, p, ({vb1, vc1} != {vb2, vc2}));
    #1;
    check_all();
  endtask

  initial begin
    logic [3:0] rb1, rc1, rb2, rc2;
    bit rs, rp, rr;
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    b1 = '0; c1 = '0; b2 = '0; c2 = '0;

    // reset
    step(1, 0, 0, 4'h3, 4'h3, 4'h3, 4'h3);
    step(1, 0, 0, 4'h3, 4'h3, 4'h3, 4'h3);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_eq",   int'(eq0),   1);
    chk("rst_cnt",  int'(cc0),   0);
    chk("rst_fev",  int'(fev0),  0);

    // all match: 10 compared cycles plus the stop cycle
    step(0, 1, 0, 4'h3, 4'h3, 4'h3, 4'h3);
    for (int k = 0; k < 12; k++) step(0, 0, 0, 4'h3, 4'h3, 4'h3, 4'h3);
    step(0, 0, 1, 4'h3, 4'h3, 4'h3, 4'h3);
    chk("allm_cnt",  int'(cc0),   11);
    chk("allm_mm",   int'(mc0),   0);
    chk("allm_fev",  int'(fev0),  0);
    chk("allm_done", int'(done0), 1);
    chk("allm_busy", int'(busy0), 0);

    // single divergence at compared cycle 4
    step(0, 1, 0, 4'h3, 4'h3, 4'h3, 4'h3);
    step(0, 0, 0, 4'h3, 4'h3, 4'h3, 4'h3);
    step(0, 0, 0, 4'h3, 4'h3, 4'h3, 4'h3);
    for (int k = 0; k < 8; k++) begin
      step(0, 0, (k == 7), 4'h3, (k == 4) ? 4'h7 : 4'h3, 4'h3, 4'h3);
      if (k == 3) chk("div_eq_before", int'(eq0), 1);
      if (k == 4) chk("div_eq_at",     int'(eq0), 0);
      if (k == 5) chk("div_eq_after",  int'(eq0), 1);
    end
    chk("div_mm",   int'(mc0),  1);
    chk("div_fidx", int'(fi0),  4);
    chk("div_cnt",  int'(cc0),  8);
    chk("div_fev",  int'(fev0), 1);

    // mismatches inside the settle window are ignored
    step(0, 1, 0, 4'h3, 4'h3, 4'h3, 4'h3);
    step(0, 0, 0, 4'h1, 4'h3, 4'h2, 4'h3);
    step(0, 0, 0, 4'h1, 4'h3, 4'h2, 4'h3);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 4'h5, 4'h6, 4'h5, 4'h6);
    step(0, 0, 1, 4'h5, 4'h6, 4'h5, 4'h6);
    chk("set_mm",   int'(mc0),   0);
    chk("set_cnt",  int'(cc0),   6);
    chk("set_done", int'(done0), 1);

    // start and stop together in DONE: start wins
    step(0, 1, 1, 4'h3, 4'h3, 4'h3, 4'h3);
    chk("col_cnt",  int'(cc0),   0);
    chk("col_mm",   int'(mc0),   0);
    chk("col_busy", int'(busy0), 1);
    chk("col_done", int'(done0), 0);
    chk("col_fev",  int'(fev0),  0);

    // reset in the middle of COMPARE
    step(0, 0, 0, 4'h3, 4'h3, 4'h3, 4'h3);
    step(0, 0, 0, 4'h3, 4'h3, 4'h3, 4'h3);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 4'h9, 4'h3, 4'h3, 4'h3);
    chk("mid_mm_pre", int'(mc0), 3);
    step(1, 0, 0, 4'h9, 4'h3, 4'h3, 4'h3);
    step(1, 0, 0, 4'h9, 4'h3, 4'h3, 4'h3);
    chk("mid_busy", int'(busy0), 0);
    chk("mid_done", int'(done0), 0);
    chk("mid_cnt",  int'(cc0),   0);
    chk("mid_mm",   int'(mc0),   0);
    chk("mid_fev",  int'(fev0),  0);
    chk("mid_eq",   int'(eq0),   1);

    // saturation on the CNT_W=4, SETTLE=0 instance: 20 mismatching compares
    step(0, 1, 0, 4'h3, 4'h3, 4'h3, 4'h3);
    for (int k = 0; k < 19; k++) step(0, 0, 0, 4'h3, 4'hA, 4'h3, 4'h3);
    step(0, 0, 1, 4'h3, 4'hA, 4'h3, 4'h3);
    chk("sat_cnt",  int'(cc1),  15);
    chk("sat_mm",   int'(mc1),  15);
    chk("sat_fidx", int'(fi1),  0);
    chk("sat_fev",  int'(fev1), 1);

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      rb1 = 4'($urandom_range(0, 15));
      rc1 = 4'($urandom_range(0, 15));
      rb2 = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : rb1;
      rc2 = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : rc1;
      rs  = ($urandom_range(0, 19) == 0);
      rp  = ($urandom_range(0, 14) == 0);
      rr  = ($urandom_range(0, 79) == 0);
      step(rr, rs, rp, rb1, rc1, rb2, rc2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
